// File: rtl/ram_dump_pkg.sv
// Shared types and helpers for the RAM-to-UART dump block.
// Optional ASCII_HEX_EN selects hex-text output (4 hex chars + CR LF per word).
package ram_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_LATCH,
    S_TX_HI,
    S_TX_LO,
    S_FIN
  } state_t;

  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP  = 1'b1;

`ifdef ASCII_HEX_EN
  localparam int BYTES_PER_WORD = 6;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] word_byte(input logic [15:0] w, input logic [2:0] k);
    case (k)
      3'd0:    return nib2ascii(w[15:12]);
      3'd1:    return nib2ascii(w[11:8]);
      3'd2:    return nib2ascii(w[7:4]);
      3'd3:    return nib2ascii(w[3:0]);
      3'd4:    return CR;
      default: return LF;
    endcase
  endfunction
`else
  localparam int BYTES_PER_WORD = 2;

  function automatic logic [7:0] word_byte(input logic [15:0] w, input logic [2:0] k);
    return (k == 3'd0) ? w[15:8] : w[7:0];
  endfunction
`endif

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: one byte per tx_valid & tx_ready handshake.
// tx_ready returns high on the cycle after the stop bit ends.
module uart_tx_byte
  import ram_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic          r_active;
  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  // r_bit: 0 = start bit, 1..8 = data LSB first, 9 = stop bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= UART_STOP;
    end else if (!r_active) begin
      if (tx_valid) begin
        r_active <= 1'b1;
        r_baud   <= '0;
        r_bit    <= '0;
        r_shift  <= tx_data;
        r_tx     <= UART_START;
      end
    end else if (r_baud == BAUD_LAST) begin
      r_baud <= '0;
      if (r_bit == 4'd9) begin
        r_active <= 1'b0;
        r_tx     <= UART_STOP;
      end else begin
        r_bit <= r_bit + 4'd1;
        r_tx  <= (r_bit == 4'd8) ? UART_STOP : r_shift[r_bit[2:0]];
      end
    end else begin
      r_baud <= r_baud + BW'(1);
    end
  end

  assign tx_ready  = !r_active;
  assign tx_serial = r_tx;

endmodule

// File: rtl/ram_dump_uart_tx.sv
// Walks RAM words 0..WORDS-1 on start and streams them out on an 8N1 UART line.
// Define ASCII_HEX_EN to send each word as hex text followed by CR LF.
module ram_dump_uart_tx
  import ram_dump_pkg::*;
#(
  parameter int ADDR_W       = 6,
  parameter int WORDS        = 64,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       data_from_ram,
  output logic              read_enable_to_ram,
  output logic [ADDR_W-1:0] address_to_ram,
  output logic              busy,
  output logic              done,
  output logic              uart_TX
);

  localparam logic [2:0]      LAST_BYTE = 3'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W + 1)'(WORDS - 1);

  state_t          r_state, w_next;
  logic [ADDR_W:0] r_idx;
  logic [15:0]     r_word;
  logic [2:0]      r_byte;
  logic            w_tx_valid, w_tx_ready;
  logic [7:0]      w_tx_data;

  // Byte 0 is handed over in LATCH straight from the RAM output so the
  // word gap stays at 4 idle cycles; TX_LO makes the next/finish decision
  // on the idle cycle after the last stop bit.
  always_comb begin
    w_next     = r_state;
    w_tx_valid = 1'b0;
    w_tx_data  = 8'h00;
    case (r_state)
      S_IDLE:    if (start) w_next = S_RD_REQ;
      S_RD_REQ:  w_next = S_RD_WAIT;
      S_RD_WAIT: w_next = S_LATCH;
      S_LATCH: begin
        w_tx_valid = 1'b1;
        w_tx_data  = word_byte(data_from_ram, 3'd0);
        w_next     = S_TX_HI;
      end
      S_TX_HI: begin
        w_tx_valid = 1'b1;
        w_tx_data  = word_byte(r_word, r_byte);
        if (w_tx_ready && r_byte == LAST_BYTE) w_next = S_TX_LO;
      end
      S_TX_LO:   if (w_tx_ready) w_next = (r_idx == LAST_IDX) ? S_FIN : S_RD_REQ;
      S_FIN:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_word  <= '0;
      r_byte  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) r_idx <= '0;
      if (r_state == S_TX_LO && w_tx_ready && r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
      if (r_state == S_LATCH) begin
        r_word <= data_from_ram;
        r_byte <= 3'd1;
      end
      if (r_state == S_TX_HI && w_tx_ready) r_byte <= r_byte + 3'd1;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (w_tx_data),
    .tx_valid  (w_tx_valid),
    .tx_ready  (w_tx_ready),
    .tx_serial (uart_TX)
  );

  assign read_enable_to_ram = (r_state == S_RD_REQ);
  assign address_to_ram     = r_idx[ADDR_W-1:0];
  assign busy               = (r_state != S_IDLE) && (r_state != S_FIN);
  assign done               = (r_state == S_FIN);

endmodule

// File: tb/tb_ram_dump_uart_tx.sv
// Bench for ram_dump_uart_tx: behavioural RAM, sampled UART line decoded
// against a byte-stream model derived from RAM contents.
module tb_ram_dump_uart_tx;

  localparam int ADDR_W = 6;
  localparam int CPB    = 4;
`ifdef ASCII_HEX_EN
  localparam int WORDS = 1;
  localparam int BPW   = 6;
`else
  localparam int WORDS = 4;
  localparam int BPW   = 2;
`endif
  localparam int FRAME = 10 * CPB;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [15:0]       data_from_ram;
  logic              read_enable_to_ram;
  logic [ADDR_W-1:0] address_to_ram;
  logic              busy;
  logic              done;
  logic              uart_TX;

  ram_dump_uart_tx #(.ADDR_W(ADDR_W), .WORDS(WORDS), .CLKS_PER_BIT(CPB)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .data_from_ram      (data_from_ram),
    .read_enable_to_ram (read_enable_to_ram),
    .address_to_ram     (address_to_ram),
    .busy               (busy),
    .done               (done),
    .uart_TX            (uart_TX)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (read_enable_to_ram) data_from_ram <= mem[address_to_ram];

  int checks = 0;
  int errors = 0;

  bit         q_tx[$];
  int         q_rd[$];
  int         n_done;
  int         busy_err;
  logic [7:0] got_b[$];
  int         got_gap[$];
  int         terr;

  function automatic logic [7:0] exp_byte(input logic [15:0] w, input int k);
`ifdef ASCII_HEX_EN
    int n;
    if (k < 4) begin
      n = int'((w >> (4 * (3 - k))) & 16'hF);
      return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    end
    return (k == 4) ? 8'h0D : 8'h0A;
`else
    return (k == 0) ? w[15:8] : w[7:0];
`endif
  endfunction

  // idle cycles before frame k; frame 0 follows RD_REQ, RD_WAIT, LATCH
  function automatic int exp_gap(input int k);
    if (k == 0) return 3;
    return (k % BPW == 0) ? 4 : 1;
  endfunction

  task automatic run_dump(input int mid_start);
    int tail = 0;
    q_tx.delete(); q_rd.delete(); n_done = 0; busy_err = 0;
    @(negedge clk); start = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      q_tx.push_back(uart_TX);
      if (read_enable_to_ram) q_rd.push_back(int'(address_to_ram));
      if (done) begin
        n_done++;
        if (busy !== 1'b0) busy_err++;
      end else if (n_done == 0 && busy !== 1'b1) busy_err++;
      start = (c == mid_start);
      if (n_done > 0) begin
        tail++;
        if (tail > 8) break;
      end
    end
    start = 1'b0;
  endtask

  task automatic decode();
    int i = 0;
    int prev = -1;
    logic [7:0] b;
    bit v;
    got_b.delete(); got_gap.delete(); terr = 0;
    while (i < q_tx.size()) begin
      if (q_tx[i] == 1'b0) begin
        if (i + FRAME > q_tx.size()) begin terr++; break; end
        b = 8'h00;
        for (int bt = 0; bt < 10; bt++) begin
          v = q_tx[i + CPB * bt];
          for (int s = 1; s < CPB; s++) if (q_tx[i + CPB * bt + s] != v) terr++;
          if (bt >= 1 && bt <= 8) b[bt-1] = v;
          if (bt == 9 && v != 1'b1) terr++;
        end
        got_b.push_back(b);
        got_gap.push_back(prev < 0 ? i : i - prev - 1);
        prev = i + FRAME - 1;
        i += FRAME;
      end else i++;
    end
  endtask

  task automatic load_fixed();
`ifdef ASCII_HEX_EN
    mem[0] = 16'hBEEF;
`else
    mem[0] = 16'hA55A; mem[1] = 16'h0001; mem[2] = 16'hFF00; mem[3] = 16'h1234;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); start = ~start;
      #1;
      checks++;
      if ({uart_TX, busy, done, read_enable_to_ram} !== 4'b1000 || address_to_ram !== '0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: tx/busy/done/ena=%b%b%b%b addr=%0d, required 1000 addr=0",
                 c, uart_TX, busy, done, read_enable_to_ram, address_to_ram);
      end
    end
    @(negedge clk); start = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_dump();
    logic [7:0] e;
    load_fixed();
    run_dump(-1);
    decode();
    checks++;
    if (got_b.size() != WORDS * BPW) begin
      errors++; $display("FAIL dump_count got %0d bytes, required %0d", got_b.size(), WORDS * BPW);
    end
    for (int k = 0; k < got_b.size() && k < WORDS * BPW; k++) begin
      e = exp_byte(mem[k / BPW], k % BPW);
      checks++;
      if (got_b[k] !== e) begin errors++; $display("FAIL dump_byte %0d got %h, required %h", k, got_b[k], e); end
    end
    checks++;
    if (q_rd.size() != WORDS) begin errors++; $display("FAIL dump_reads got %0d, required %0d", q_rd.size(), WORDS); end
    for (int k = 0; k < q_rd.size() && k < WORDS; k++) begin
      checks++;
      if (q_rd[k] != k) begin errors++; $display("FAIL dump_addr %0d got %0d, required %0d", k, q_rd[k], k); end
    end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL dump_done pulses got %0d, required 1", n_done); end
    checks++;
    if (busy_err != 0) begin errors++; $display("FAIL dump_busy got %0d bad cycles, required 0", busy_err); end
    checks++;
    if (address_to_ram !== ADDR_W'(WORDS - 1)) begin
      errors++; $display("FAIL addr_hold got %0d, required %0d", address_to_ram, WORDS - 1);
    end
  endtask

  task automatic test_timing();
    load_fixed();
    run_dump(-1);
    decode();
    checks++;
    if (terr != 0) begin errors++; $display("FAIL bit_timing got %0d bad bits, required 0", terr); end
    checks++;
    if (got_gap.size() != WORDS * BPW) begin
      errors++; $display("FAIL gap_count got %0d, required %0d", got_gap.size(), WORDS * BPW);
    end
    for (int k = 0; k < got_gap.size() && k < WORDS * BPW; k++) begin
      checks++;
      if (got_gap[k] != exp_gap(k)) begin
        errors++; $display("FAIL idle_gap before byte %0d got %0d, required %0d", k, got_gap[k], exp_gap(k));
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] e;
    load_fixed();
    run_dump(100);
    decode();
    checks++;
    if (got_b.size() != WORDS * BPW || q_rd.size() != WORDS || n_done != 1) begin
      errors++;
      $display("FAIL start_ignored bytes/reads/done got %0d/%0d/%0d, required %0d/%0d/1",
               got_b.size(), q_rd.size(), n_done, WORDS * BPW, WORDS);
    end
    for (int k = 0; k < got_b.size() && k < WORDS * BPW; k++) begin
      e = exp_byte(mem[k / BPW], k % BPW);
      checks++;
      if (got_b[k] !== e) begin errors++; $display("FAIL start_ignored byte %0d got %h, required %h", k, got_b[k], e); end
    end
  endtask

  task automatic test_reset_mid();
    int k = 3;
    int s = exp_gap(0);
    int target;
    logic [7:0] eb;
    logic [7:0] e;
    load_fixed();
    for (int j = 0; j < k; j++) s += FRAME + exp_gap(j + 1);
    target = s + CPB * 2 + 1;
    eb = exp_byte(mem[k / BPW], k % BPW);
    @(negedge clk); start = 1'b1;
    for (int c = 0; c <= target; c++) begin
      @(negedge clk); start = 1'b0;
    end
    checks++;
    if (uart_TX !== eb[1]) begin errors++; $display("FAIL mid_frame_line got %b, required %b", uart_TX, eb[1]); end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({uart_TX, busy, done, read_enable_to_ram} !== 4'b1000 || address_to_ram !== '0) begin
      errors++;
      $display("FAIL async_reset tx/busy/done/ena=%b%b%b%b addr=%0d, required 1000 addr=0",
               uart_TX, busy, done, read_enable_to_ram, address_to_ram);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_dump(-1);
    decode();
    checks++;
    if (got_b.size() != WORDS * BPW || q_rd.size() != WORDS || n_done != 1) begin
      errors++;
      $display("FAIL post_reset bytes/reads/done got %0d/%0d/%0d, required %0d/%0d/1",
               got_b.size(), q_rd.size(), n_done, WORDS * BPW, WORDS);
    end
    checks++;
    if (q_rd.size() == 0 || q_rd[0] != 0) begin errors++; $display("FAIL post_reset first read address not 0, required 0"); end
    for (int i = 0; i < got_b.size() && i < WORDS * BPW; i++) begin
      e = exp_byte(mem[i / BPW], i % BPW);
      checks++;
      if (got_b[i] !== e) begin errors++; $display("FAIL post_reset byte %0d got %h, required %h", i, got_b[i], e); end
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int it = 0; it < 3; it++) begin
      for (int w = 0; w < WORDS; w++) mem[w] = 16'($urandom);
      run_dump(int'($urandom_range(5, 150)));
      decode();
      checks++;
      if (got_b.size() != WORDS * BPW || q_rd.size() != WORDS || n_done != 1 || terr != 0) begin
        errors++;
        $display("FAIL random_run %0d bytes/reads/done/terr got %0d/%0d/%0d/%0d, required %0d/%0d/1/0",
                 it, got_b.size(), q_rd.size(), n_done, terr, WORDS * BPW, WORDS);
      end
      for (int k = 0; k < got_b.size() && k < WORDS * BPW; k++) begin
        e = exp_byte(mem[k / BPW], k % BPW);
        checks++;
        if (got_b[k] !== e) begin errors++; $display("FAIL random_byte run %0d byte %0d got %h, required %h", it, k, got_b[k], e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_dump();
    test_timing();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
